// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths, FSM encoding and grant ids for the cache/memory arbiter
package mem_arbiter_pkg;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GNT_I   = 2'b01,
        GNT_D   = 2'b10,
        RELEASE = 2'b11
    } arb_state_t;

    localparam logic GNT_ID_I = 1'b0;
    localparam logic GNT_ID_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - line-transfer port (read/write request, data, ready) shared by caches and memory
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arbiter_pkg::ADDR_W,
    parameter int DATA_W = mem_arbiter_pkg::DATA_W
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    // master issues requests, slave completes them
    modport master (output read, write, addr, wdata, input rdata, ready);
    modport slave  (input read, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - merges I-cache and D-cache line requests onto one memory port
// ARB_ROUND_ROBIN_EN selects round-robin on simultaneous requests; default is fixed D-over-I.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          proc_reset,
    mem_arbiter_if.slave  i_mem,
    mem_arbiter_if.slave  d_mem,
    mem_arbiter_if.master mem
);

    arb_state_t        state, state_nxt;
    logic              i_req, d_req, pick_d;
    logic              mem_read_q, mem_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    assign i_req = i_mem.read | i_mem.write;
    assign d_req = d_mem.read | d_mem.write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_gnt;

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            last_gnt <= GNT_ID_D;
        end else if (state == IDLE && (i_req || d_req)) begin
            last_gnt <= pick_d ? GNT_ID_D : GNT_ID_I;
        end
    end

    always_comb begin
        pick_d = d_req;
        if (d_req && i_req) begin
            pick_d = (last_gnt == GNT_ID_I);
        end
    end
`else
    always_comb begin
        pick_d = d_req;
    end
`endif

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    state_nxt = pick_d ? GNT_D : GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (mem.ready) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // read+write together is illegal; write wins so a dirty line is never lost
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else if (state == IDLE && (i_req || d_req)) begin
            if (pick_d) begin
                mem_write_q <= d_mem.write;
                mem_read_q  <= d_mem.read & ~d_mem.write;
                addr_q      <= d_mem.addr;
                wdata_q     <= d_mem.wdata;
            end else begin
                mem_write_q <= i_mem.write;
                mem_read_q  <= i_mem.read & ~i_mem.write;
                addr_q      <= i_mem.addr;
                wdata_q     <= i_mem.wdata;
            end
        end else if ((state == GNT_I || state == GNT_D) && mem.ready) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end
    end

    assign mem.read  = mem_read_q;
    assign mem.write = mem_write_q;
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;

    assign i_mem.ready = (state == GNT_I) && mem.ready;
    assign i_mem.rdata = (state == GNT_I) ? mem.rdata : '0;
    assign d_mem.ready = (state == GNT_D) && mem.ready;
    assign d_mem.rdata = (state == GNT_D) ? mem.rdata : '0;

    a_i_rw_exclusive: assert property (@(posedge clk) disable iff (proc_reset)
        !(i_mem.read && i_mem.write));
    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (proc_reset)
        !(d_mem.read && d_mem.write));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic proc_reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    mem_arbiter_if i_if ();
    mem_arbiter_if d_if ();
    mem_arbiter_if m_if ();

    mem_arbiter dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .i_mem      (i_if),
        .d_mem      (d_if),
        .mem        (m_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // returns at the first negedge where a memory strobe is visible
    task automatic wait_strobe(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (m_if.read || m_if.write) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic drive_ready(input logic [DATA_W-1:0] rd);
        m_if.rdata = rd;
        m_if.ready = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        bit ok;
        int n;
        @(negedge clk);
        total++; if (m_if.read !== 1'b0 || m_if.write !== 1'b0) begin bad++; $display("FAIL reset_strobes: got r=%b w=%b want 0 0", m_if.read, m_if.write); end
        total++; if (m_if.addr !== '0 || m_if.wdata !== '0) begin bad++; $display("FAIL reset_addr_data: got addr=%h wdata=%h want 0", m_if.addr, m_if.wdata); end
        total++; if (i_if.ready !== 1'b0 || d_if.ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got i=%b d=%b want 0 0", i_if.ready, d_if.ready); end
        proc_reset = 1'b0;
        i_if.read = 1'b1; i_if.addr = 28'h0000070;
        wait_strobe(ok, n);
        total++; if (!ok || m_if.addr !== 28'h0000070) begin bad++; $display("FAIL reset_pre_grant: got ok=%0d addr=%h want 1 0000070", ok, m_if.addr); end
        #2 proc_reset = 1'b1;
        m_if.ready = 1'b1;
        #1;
        total++; if (m_if.read !== 1'b0 || m_if.addr !== '0) begin bad++; $display("FAIL reset_async: got r=%b addr=%h want 0 0", m_if.read, m_if.addr); end
        total++; if (dut.state !== IDLE || i_if.ready !== 1'b0) begin bad++; $display("FAIL reset_async_state: got state=%0d iready=%b want 0 0", dut.state, i_if.ready); end
        i_if.read = 1'b0; m_if.ready = 1'b0;
        @(negedge clk);
        proc_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stray_ready();
        drive_ready({16{8'h5A}});
        total++; if (i_if.ready !== 1'b0 || d_if.ready !== 1'b0 || i_if.rdata !== '0) begin bad++; $display("FAIL stray_ready: got i=%b d=%b irdata=%h want 0 0 0", i_if.ready, d_if.ready, i_if.rdata); end
        @(negedge clk);
        m_if.ready = 1'b0; m_if.rdata = '0;
        total++; if (dut.state !== IDLE || m_if.read !== 1'b0) begin bad++; $display("FAIL stray_state: got state=%0d r=%b want 0 0", dut.state, m_if.read); end
    endtask

    task automatic test_lone_i_read();
        bit ok;
        int n;
        i_if.read = 1'b1; i_if.addr = 28'h0000010;
        wait_strobe(ok, n);
        total++; if (!ok || n != 1) begin bad++; $display("FAIL lone_i_latency: got ok=%0d cycles=%0d want 1 1", ok, n); end
        total++; if (m_if.read !== 1'b1 || m_if.write !== 1'b0 || m_if.addr !== 28'h0000010) begin bad++; $display("FAIL lone_i_strobe: got r=%b w=%b addr=%h want 1 0 0000010", m_if.read, m_if.write, m_if.addr); end
        drive_ready({16{8'hA5}});
        total++; if (i_if.ready !== 1'b1 || i_if.rdata !== {16{8'hA5}}) begin bad++; $display("FAIL lone_i_ready: got ready=%b rdata=%h want 1 a5..", i_if.ready, i_if.rdata); end
        total++; if (d_if.ready !== 1'b0 || d_if.rdata !== '0) begin bad++; $display("FAIL lone_i_other: got dready=%b drdata=%h want 0 0", d_if.ready, d_if.rdata); end
        @(negedge clk);
        m_if.ready = 1'b0; m_if.rdata = '0; i_if.read = 1'b0;
        total++; if (m_if.read !== 1'b0 || dut.state !== RELEASE) begin bad++; $display("FAIL lone_i_release: got r=%b state=%0d want 0 3", m_if.read, dut.state); end
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        bit ok;
        int n;
        i_if.read = 1'b1; i_if.addr = 28'h0000010;
        d_if.read = 1'b1; d_if.addr = 28'h0000020;
        wait_strobe(ok, n);
        total++; if (!ok || m_if.addr !== 28'h0000020) begin bad++; $display("FAIL sim_first: got ok=%0d addr=%h want 1 0000020", ok, m_if.addr); end
        drive_ready(128'h1);
        total++; if (d_if.ready !== 1'b1 || i_if.ready !== 1'b0) begin bad++; $display("FAIL sim_first_ready: got d=%b i=%b want 1 0", d_if.ready, i_if.ready); end
        @(negedge clk);
        m_if.ready = 1'b0; d_if.read = 1'b0;
        total++; if (m_if.read !== 1'b0) begin bad++; $display("FAIL sim_release: got r=%b want 0", m_if.read); end
        wait_strobe(ok, n);
        total++; if (!ok || n != 2 || m_if.addr !== 28'h0000010) begin bad++; $display("FAIL sim_second: got ok=%0d cycles=%0d addr=%h want 1 2 0000010", ok, n, m_if.addr); end
        drive_ready(128'h2);
        total++; if (i_if.ready !== 1'b1 || i_if.rdata !== 128'h2 || d_if.ready !== 1'b0) begin bad++; $display("FAIL sim_second_ready: got i=%b rdata=%h d=%b want 1 2 0", i_if.ready, i_if.rdata, d_if.ready); end
        @(negedge clk);
        m_if.ready = 1'b0; i_if.read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_writeback_alloc();
        bit ok;
        int n;
        d_if.write = 1'b1; d_if.addr = 28'h0000030; d_if.wdata = 128'h1234;
        wait_strobe(ok, n);
        total++; if (!ok || m_if.write !== 1'b1 || m_if.read !== 1'b0) begin bad++; $display("FAIL wb_strobe: got ok=%0d w=%b r=%b want 1 1 0", ok, m_if.write, m_if.read); end
        total++; if (m_if.wdata !== 128'h1234 || m_if.addr !== 28'h0000030) begin bad++; $display("FAIL wb_data: got wdata=%h addr=%h want 1234 0000030", m_if.wdata, m_if.addr); end
        drive_ready('0);
        total++; if (d_if.ready !== 1'b1) begin bad++; $display("FAIL wb_ready: got %b want 1", d_if.ready); end
        @(negedge clk);
        m_if.ready = 1'b0;
        d_if.write = 1'b0; d_if.read = 1'b1; d_if.addr = 28'h0000040;
        wait_strobe(ok, n);
        total++; if (!ok || n != 2) begin bad++; $display("FAIL alloc_gap: got ok=%0d cycles=%0d want 1 2", ok, n); end
        total++; if (m_if.read !== 1'b1 || m_if.write !== 1'b0 || m_if.addr !== 28'h0000040) begin bad++; $display("FAIL alloc_strobe: got r=%b w=%b addr=%h want 1 0 0000040", m_if.read, m_if.write, m_if.addr); end
        drive_ready(128'hBEEF);
        total++; if (d_if.ready !== 1'b1 || d_if.rdata !== 128'hBEEF) begin bad++; $display("FAIL alloc_ready: got ready=%b rdata=%h want 1 beef", d_if.ready, d_if.rdata); end
        @(negedge clk);
        m_if.ready = 1'b0; m_if.rdata = '0; d_if.read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_grant();
        bit ok;
        int n;
        d_if.read = 1'b1; d_if.addr = 28'h0000050;
        wait_strobe(ok, n);
        total++; if (!ok || dut.state !== GNT_D) begin bad++; $display("FAIL rmg_grant: got ok=%0d state=%0d want 1 2", ok, dut.state); end
        #2 proc_reset = 1'b1;
        #1;
        total++; if (m_if.read !== 1'b0 || m_if.write !== 1'b0 || d_if.ready !== 1'b0) begin bad++; $display("FAIL rmg_abandon: got r=%b w=%b dready=%b want 0 0 0", m_if.read, m_if.write, d_if.ready); end
        d_if.read = 1'b0;
        @(negedge clk);
        proc_reset = 1'b0;
        i_if.read = 1'b1; i_if.addr = 28'h0000060;
        wait_strobe(ok, n);
        total++; if (!ok || n != 1 || m_if.addr !== 28'h0000060) begin bad++; $display("FAIL rmg_new_i: got ok=%0d cycles=%0d addr=%h want 1 1 0000060", ok, n, m_if.addr); end
        drive_ready(128'h77);
        total++; if (i_if.ready !== 1'b1 || d_if.ready !== 1'b0) begin bad++; $display("FAIL rmg_new_ready: got i=%b d=%b want 1 0", i_if.ready, d_if.ready); end
        @(negedge clk);
        m_if.ready = 1'b0; m_if.rdata = '0; i_if.read = 1'b0;
        @(negedge clk);
    endtask

    // last grant before this test is I, so round-robin starts with D
    task automatic test_back_to_back();
        bit ok;
        int n;
        logic [ADDR_W-1:0] exp_addr [4];
`ifdef ARB_ROUND_ROBIN_EN
        exp_addr = '{28'h0000200, 28'h0000100, 28'h0000200, 28'h0000100};
`else
        exp_addr = '{28'h0000200, 28'h0000200, 28'h0000200, 28'h0000200};
`endif
        i_if.read = 1'b1; i_if.addr = 28'h0000100;
        d_if.read = 1'b1; d_if.addr = 28'h0000200;
        for (int t = 0; t < 4; t++) begin
            wait_strobe(ok, n);
            total++; if (!ok || m_if.addr !== exp_addr[t]) begin bad++; $display("FAIL b2b_grant%0d: got ok=%0d addr=%h want 1 %h", t, ok, m_if.addr, exp_addr[t]); end
            drive_ready(128'(t));
            @(negedge clk);
            m_if.ready = 1'b0;
        end
        i_if.read = 1'b0; d_if.read = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        i_if.read = 1'b0; i_if.write = 1'b0; i_if.addr = '0; i_if.wdata = '0;
        d_if.read = 1'b0; d_if.write = 1'b0; d_if.addr = '0; d_if.wdata = '0;
        m_if.ready = 1'b0; m_if.rdata = '0;
        test_reset();
        test_stray_ready();
        test_lone_i_read();
        test_simultaneous();
        test_writeback_alloc();
        test_reset_mid_grant();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
